bsg_manycore_ruche_edge_concentrator: RTL and testbench
=======================================================

BSG_MANYCORE_RUCHE_EDGE_CONCENTRATOR -- requirements
Module: bsg_manycore_ruche_edge_concentrator

Interface
REQ-001 The block SHALL take parameter num_channels_p, default 3, giving the number of ruche channels concentrated at a row edge; legal values are 1 to 8.
REQ-002 The block SHALL take parameter width_p, default 32, giving the payload width per channel.
REQ-003 The block SHALL take parameter fifo_els_p, default 2, giving the depth of each per-channel FIFO, egress and ingress; legal values are 2 or more.
REQ-004 The block SHALL derive local parameter id_width_lp = max(1, ceil(log2(num_channels_p))).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- chan_en_i, input, num_channels_p: per-channel enable; a disabled channel replaces the fixed tieoff.
- ch_data_i, input, num_channels_p x width_p: egress payload.
- ch_v_i, input, num_channels_p: egress valid.
- ch_ready_o, output, num_channels_p: egress ready.
- link_data_o, output, id_width_lp+width_p: concentrated output; channel id is in the MSBs.
- link_v_o, output, 1: output valid.
- link_ready_i, input, 1: output ready.
- link_data_i, input, id_width_lp+width_p: concentrated input; channel id is in the MSBs.
- link_v_i, input, 1: input valid.
- link_ready_o, output, 1: input ready.
- ch_data_o, output, num_channels_p x width_p: ingress payload.
- ch_v_o, output, num_channels_p: ingress valid.
- ch_ready_i, input, num_channels_p: ingress ready.
- error_o, output, 1: sticky flag, set when an ingress packet is dropped.
- drop_count_o, output, 8: saturating count of dropped ingress packets.

Function
REQ-006 Every handshake SHALL be ready-and-valid: a transfer occurs on a rising edge where valid and ready are both 1.
REQ-007 ch_ready_o[c] SHALL equal chan_en_i[c] AND (egress FIFO c not full).
REQ-008 An accepted egress word SHALL become visible at the FIFO head in the cycle after acceptance; the minimum latency from ch_v_i to link_v_o is 1 cycle.
REQ-009 link_v_o SHALL be 1 when at least one enabled channel has a non-empty egress FIFO.
REQ-010 The grant SHALL be round-robin, starting the search at rr_ptr; link_data_o SHALL be {granted id, head word of the granted FIFO}.
REQ-011 While link_v_o=1 and link_ready_i=0, the grant SHALL be locked, and link_data_o SHALL stay stable even if higher-priority channels become non-empty.
REQ-012 On an output transfer, the granted FIFO SHALL dequeue one word, and rr_ptr SHALL become (granted id + 1) mod num_channels_p.
REQ-013 A channel with chan_en_i=0 SHALL be excluded from arbitration; its FIFO contents SHALL be retained and resume draining when it is re-enabled.
REQ-014 A locked grant on a channel disabled mid-stall SHALL complete its pending transfer before the lock releases.
REQ-015 An egress FIFO written and read in the same cycle while full SHALL accept the write, so full-FIFO throughput is 1 word per cycle.
REQ-016 Ingress: with id = link_data_i MSBs, link_ready_o SHALL be 1 if the id is invalid (id ≥ num_channels_p or chan_en_i[id]=0); otherwise it SHALL equal (ingress FIFO id not full).
REQ-017 Every ingress transfer with a valid id SHALL enqueue the payload into ingress FIFO id.
REQ-018 Every ingress transfer with an invalid id SHALL be dropped, SHALL set error_o the next cycle, and SHALL increment drop_count_o, saturating at 255.
REQ-019 ch_v_o[c] SHALL equal (ingress FIFO c non-empty); ch_data_o[c] SHALL be the head word of FIFO c; a transfer on ch_ready_i[c] SHALL dequeue FIFO c.
REQ-020 Egress and ingress paths SHALL be fully independent and SHALL each sustain 1 transfer per cycle concurrently.
REQ-021 No output SHALL depend combinationally on the same path's ready input, except ch_ready_o via FIFO same-cycle dequeue and link_ready_o via link_data_i.

Reset
REQ-022 While reset_i=1 at a rising edge, all FIFOs SHALL be emptied and rr_ptr, error_o and drop_count_o SHALL be set to 0.
REQ-023 During and after reset, link_v_o=0, ch_v_o=0 and ch_ready_o=0 SHALL hold for the reset cycle; ch_ready_o SHALL follow REQ-007 from the first cycle after reset deasserts.
REQ-024 Reset asserted mid-stall SHALL discard all buffered words and SHALL drop the grant lock.

Verification
REQ-025 The bench SHALL cover: N=3, all enabled, ch_v_i=111 held and link_ready_i=1 -> link_data_o ids 0,1,2,0,1,2 on consecutive cycles.
REQ-026 The bench SHALL cover: channel 1 head 0xA5, link_ready_i=0 for 5 cycles, channel 0 becomes valid -> link_data_o stays {1,0xA5} until the ready cycle, then rr_ptr=2.
REQ-027 The bench SHALL cover: chan_en_i=101 -> ch_ready_o[1]=0, id 1 is never granted, and an ingress packet with id 1 is dropped with error_o=1 and drop_count_o=1.
REQ-028 The bench SHALL cover: 300 ingress packets with id 3 at N=3 -> drop_count_o saturates at 255 and link_ready_o stays 1.
REQ-029 The bench SHALL cover: ch_ready_i[2]=0 with fifo_els_p=2 and two words to id 2 -> link_ready_o=0 for a third id-2 word, while id-0 words are still accepted.
REQ-030 The bench SHALL cover: reset asserted with 2 words in each FIFO -> next cycle all valids=0 and drop_count_o=0; the first post-reset grant is channel 0.

Source files
------------

// File: rtl/bsg_manycore_ruche_edge_concentrator.sv
// Ruche edge concentrator: merges the ruche channels at a row edge onto one
// link with a channel id in the MSBs (egress), and splits that link back out
// into per-channel FIFOs (ingress). Each direction is independent.
module bsg_manycore_ruche_edge_concentrator #(
  parameter int num_channels_p = 3,
  parameter int width_p        = 32,
  parameter int fifo_els_p     = 2,
  localparam int id_width_lp   = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_channels_p-1:0]               chan_en_i,

  input  logic [num_channels_p-1:0][width_p-1:0]  ch_data_i,
  input  logic [num_channels_p-1:0]               ch_v_i,
  output logic [num_channels_p-1:0]               ch_ready_o,

  output logic [id_width_lp+width_p-1:0]          link_data_o,
  output logic                                    link_v_o,
  input  logic                                    link_ready_i,

  input  logic [id_width_lp+width_p-1:0]          link_data_i,
  input  logic                                    link_v_i,
  output logic                                    link_ready_o,

  output logic [num_channels_p-1:0][width_p-1:0]  ch_data_o,
  output logic [num_channels_p-1:0]               ch_v_o,
  input  logic [num_channels_p-1:0]               ch_ready_i,

  output logic                                    error_o,
  output logic [7:0]                              drop_count_o
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

  // Advance a FIFO pointer, wrapping at the FIFO depth.
  function automatic logic [ptr_w_lp-1:0] f_next_ptr(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(fifo_els_p - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Channel id that follows the given one, modulo the channel count.
  function automatic logic [id_width_lp-1:0] f_next_id(input logic [id_width_lp-1:0] id);
    if (id == id_width_lp'(num_channels_p - 1)) return '0;
    return id + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Egress path: per-channel FIFOs feeding a round-robin arbiter with a lock
  // ---------------------------------------------------------------------------
  logic [num_channels_p-1:0][width_p-1:0] w_eg_head;
  logic [num_channels_p-1:0]              w_eg_nonempty;
  logic [num_channels_p-1:0]              w_eg_full;
  logic [num_channels_p-1:0]              w_eg_ready;
  logic [num_channels_p-1:0]              w_eg_enq;
  logic [num_channels_p-1:0]              w_eg_deq;
  logic [num_channels_p-1:0]              w_eg_req;

  logic [id_width_lp-1:0] r_rr_ptr;
  logic                   r_locked;
  logic [id_width_lp-1:0] r_lock_id;

  logic                   w_any_req;
  logic [id_width_lp-1:0] w_search_id;
  logic [id_width_lp-1:0] w_grant_id;
  logic [width_p-1:0]     w_link_payload;
  logic                   w_out_xfer;
  int                     w_dist;
  int                     w_best_dist;

  // A full FIFO still accepts a word when its head leaves in the same cycle,
  // which keeps a saturated channel streaming at one word per cycle.
  assign w_eg_ready = {num_channels_p{!reset_i}} & chan_en_i & (~w_eg_full | w_eg_deq);
  assign w_eg_enq   = ch_v_i & w_eg_ready;
  assign ch_ready_o = w_eg_ready;

  // Disabled channels keep their words but do not compete for the link.
  assign w_eg_req   = chan_en_i & w_eg_nonempty;

  for (genvar gc = 0; gc < num_channels_p; gc++) begin : g_egress
    logic [width_p-1:0]  r_mem [fifo_els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;

    // Storage is not reset; the occupancy count decides what is visible.
    always_ff @(posedge clk_i) begin
      if (w_eg_enq[gc]) r_mem[r_wr_ptr] <= ch_data_i[gc];
    end

    // Pointer and occupancy bookkeeping for this channel's egress FIFO.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_eg_enq[gc]) r_wr_ptr <= f_next_ptr(r_wr_ptr);
        if (w_eg_deq[gc]) r_rd_ptr <= f_next_ptr(r_rd_ptr);
        case ({w_eg_enq[gc], w_eg_deq[gc]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    assign w_eg_head[gc]     = r_mem[r_rd_ptr];
    assign w_eg_nonempty[gc] = (r_count != '0);
    assign w_eg_full[gc]     = (r_count == cnt_w_lp'(fifo_els_p));
  end

  // Round-robin search: pick the requester closest to rr_ptr going upward.
  always_comb begin
    w_any_req   = 1'b0;
    w_search_id = '0;
    w_dist      = 0;
    w_best_dist = num_channels_p;
    for (int c = 0; c < num_channels_p; c++) begin
      if (w_eg_req[c]) begin
        if (c >= int'(r_rr_ptr)) w_dist = c - int'(r_rr_ptr);
        else                     w_dist = c + num_channels_p - int'(r_rr_ptr);
        if (w_dist < w_best_dist) begin
          w_best_dist = w_dist;
          w_search_id = id_width_lp'(c);
          w_any_req   = 1'b1;
        end
      end
    end
  end

  // A stalled grant holds until it transfers, even if its channel is disabled
  // meanwhile, so the link word never changes under a waiting receiver.
  assign w_grant_id  = r_locked ? r_lock_id : w_search_id;
  assign link_v_o    = !reset_i && (r_locked || w_any_req);
  assign w_out_xfer  = link_v_o && link_ready_i;
  assign link_data_o = {w_grant_id, w_link_payload};

  // Route the granted head onto the link and dequeue it on a transfer.
  always_comb begin
    w_eg_deq       = '0;
    w_link_payload = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (w_grant_id == id_width_lp'(c)) begin
        w_link_payload = w_eg_head[c];
        w_eg_deq[c]    = w_out_xfer;
      end
    end
  end

  // Arbiter state: rotate priority past the winner, lock on a stall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr  <= '0;
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_out_xfer) begin
      r_rr_ptr  <= f_next_id(w_grant_id);
      r_locked  <= 1'b0;
    end else if (link_v_o) begin
      r_locked  <= 1'b1;
      r_lock_id <= w_grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Ingress path: decode id, steer into per-channel FIFOs, drop bad ids
  // ---------------------------------------------------------------------------
  logic [id_width_lp-1:0]                 w_in_id;
  logic [width_p-1:0]                     w_in_payload;
  logic                                   w_in_id_ok;
  logic                                   w_in_sel_full;
  logic                                   w_in_xfer;
  logic                                   w_drop;
  logic [num_channels_p-1:0]              w_in_enq;
  logic [num_channels_p-1:0]              w_in_deq;
  logic [num_channels_p-1:0]              w_in_full;
  logic [num_channels_p-1:0]              w_in_nonempty;
  logic [num_channels_p-1:0]              w_in_valid;
  logic [num_channels_p-1:0][width_p-1:0] w_in_head;

  logic       r_error;
  logic [7:0] r_drop_count;

  assign w_in_id      = link_data_i[width_p +: id_width_lp];
  assign w_in_payload = link_data_i[width_p-1:0];

  // Look up whether the incoming id names an enabled channel, and its fullness.
  always_comb begin
    w_in_id_ok    = 1'b0;
    w_in_sel_full = 1'b0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (w_in_id == id_width_lp'(c)) begin
        w_in_id_ok    = chan_en_i[c];
        w_in_sel_full = w_in_full[c];
      end
    end
  end

  // Bad ids are always accepted so a misrouted word cannot wedge the link.
  assign link_ready_o = !w_in_id_ok || !w_in_sel_full;
  assign w_in_xfer    = link_v_i && link_ready_o;
  assign w_drop       = w_in_xfer && !w_in_id_ok;

  // One-hot enqueue strobe for the addressed ingress FIFO.
  always_comb begin
    w_in_enq = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      w_in_enq[c] = w_in_xfer && w_in_id_ok && (w_in_id == id_width_lp'(c));
    end
  end

  assign w_in_valid = {num_channels_p{!reset_i}} & w_in_nonempty;
  assign w_in_deq   = w_in_valid & ch_ready_i;
  assign ch_v_o     = w_in_valid;
  assign ch_data_o  = w_in_head;

  for (genvar gc = 0; gc < num_channels_p; gc++) begin : g_ingress
    logic [width_p-1:0]  r_mem [fifo_els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;

    // Storage is not reset; the occupancy count decides what is visible.
    always_ff @(posedge clk_i) begin
      if (w_in_enq[gc]) r_mem[r_wr_ptr] <= w_in_payload;
    end

    // Pointer and occupancy bookkeeping for this channel's ingress FIFO.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_in_enq[gc]) r_wr_ptr <= f_next_ptr(r_wr_ptr);
        if (w_in_deq[gc]) r_rd_ptr <= f_next_ptr(r_rd_ptr);
        case ({w_in_enq[gc], w_in_deq[gc]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    assign w_in_head[gc]     = r_mem[r_rd_ptr];
    assign w_in_nonempty[gc] = (r_count != '0);
    assign w_in_full[gc]     = (r_count == cnt_w_lp'(fifo_els_p));
  end

  // Sticky error flag and saturating drop counter for misrouted words.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_error      <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_error <= 1'b1;
      if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign error_o      = r_error;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_bsg_manycore_ruche_edge_concentrator.sv
// Directed bench for the ruche edge concentrator at its default sizing
// (3 channels, 32-bit payload, 2-deep FIFOs).
module tb_bsg_manycore_ruche_edge_concentrator;

  logic             clk;
  logic             reset;
  logic [2:0]       chanEn;
  logic [2:0][31:0] chDataIn;
  logic [2:0]       chValidIn;
  logic [2:0]       chReadyOut;
  logic [33:0]      linkDataOut;
  logic             linkValidOut;
  logic             linkReadyIn;
  logic [33:0]      linkDataIn;
  logic             linkValidIn;
  logic             linkReadyOut;
  logic [2:0][31:0] chDataOut;
  logic [2:0]       chValidOut;
  logic [2:0]       chReadyIn;
  logic             errorOut;
  logic [7:0]       dropCount;

  int nChecks = 0;
  int nFails  = 0;

  bsg_manycore_ruche_edge_concentrator dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .chan_en_i    (chanEn),
    .ch_data_i    (chDataIn),
    .ch_v_i       (chValidIn),
    .ch_ready_o   (chReadyOut),
    .link_data_o  (linkDataOut),
    .link_v_o     (linkValidOut),
    .link_ready_i (linkReadyIn),
    .link_data_i  (linkDataIn),
    .link_v_i     (linkValidIn),
    .link_ready_o (linkReadyOut),
    .ch_data_o    (chDataOut),
    .ch_v_o       (chValidOut),
    .ch_ready_i   (chReadyIn),
    .error_o      (errorOut),
    .drop_count_o (dropCount)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Move to the next falling edge and drive the per-cycle control inputs.
  task automatic applyStimulus(input logic [2:0] chV, input logic linkReady, input logic linkV,
                               input logic [33:0] linkData, input logic [2:0] chReady);
    @(negedge clk);
    chValidIn   = chV;
    linkReadyIn = linkReady;
    linkValidIn = linkV;
    linkDataIn  = linkData;
    chReadyIn   = chReady;
  endtask

  // Hold reset for two rising edges with all handshakes idle.
  task automatic doReset();
    @(negedge clk);
    reset       = 1'b1;
    chValidIn   = '0;
    linkValidIn = 1'b0;
    linkReadyIn = 1'b0;
    chReadyIn   = '0;
    linkDataIn  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    chanEn      = 3'b111;
    chDataIn    = '0;
    chValidIn   = '0;
    linkReadyIn = 1'b0;
    linkDataIn  = '0;
    linkValidIn = 1'b0;
    chReadyIn   = '0;

    // Reset state: outputs quiet while reset is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_link_v", 64'(linkValidOut), 64'h0);
    checkOutput("rst_ch_v", 64'(chValidOut), 64'h0);
    checkOutput("rst_ch_ready", 64'(chReadyOut), 64'h0);
    checkOutput("rst_error", 64'(errorOut), 64'h0);
    checkOutput("rst_drop", 64'(dropCount), 64'h0);

    // Round-robin with all channels streaming and the link always ready.
    doReset();
    chanEn   = 3'b111;
    chDataIn = {32'h102, 32'h101, 32'h100};
    applyStimulus(3'b111, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("rr_first_empty", 64'(linkValidOut), 64'h0);
    checkOutput("rr_first_ready", 64'(chReadyOut), 64'h7);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b111, 1'b1, 1'b0, '0, 3'b000);
      #1;
      checkOutput("rr_grant", 64'({linkValidOut, linkDataOut}),
                  64'({1'b1, 2'(k % 3), 32'h100 + 32'(k % 3)}));
    end

    // Lock: channel 1 stalls for five cycles while others fill up.
    doReset();
    chanEn   = 3'b111;
    chDataIn = {32'h0, 32'hA5, 32'h0};
    applyStimulus(3'b010, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_idle", 64'(linkValidOut), 64'h0);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_stall1", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'hA5}));
    applyStimulus(3'b111, 1'b0, 1'b0, '0, 3'b000);
    chDataIn = {32'hC7, 32'hB6, 32'h5A};
    #1;
    checkOutput("lock_stall2", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'hA5}));
    checkOutput("lock_ch_ready", 64'(chReadyOut), 64'h7);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
      #1;
      checkOutput("lock_stall_held", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'hA5}));
    end
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_release", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'hA5}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_rr_ptr2", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd2, 32'hC7}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_next0", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd0, 32'h5A}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_next1", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'hB6}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("lock_drained", 64'(linkValidOut), 64'h0);

    // Channel 1 disabled: no egress ready, never granted, ingress id 1 dropped.
    doReset();
    chanEn   = 3'b101;
    chDataIn = {32'h33, 32'h22, 32'h11};
    applyStimulus(3'b111, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("dis_ch_ready", 64'(chReadyOut), 64'h5);
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("dis_grant0", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd0, 32'h11}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("dis_grant2", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd2, 32'h33}));
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("dis_no_id1", 64'(linkValidOut), 64'h0);
    applyStimulus(3'b000, 1'b1, 1'b1, {2'd1, 32'hDEAD}, 3'b000);
    #1;
    checkOutput("dis_in_ready", 64'(linkReadyOut), 64'h1);
    checkOutput("dis_err_before", 64'(errorOut), 64'h0);
    applyStimulus(3'b000, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("dis_error", 64'(errorOut), 64'h1);
    checkOutput("dis_drop", 64'(dropCount), 64'h1);
    checkOutput("dis_no_ingress", 64'(chValidOut), 64'h0);

    // Saturation: 300 misrouted packets with id 3.
    doReset();
    chanEn = 3'b111;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(3'b000, 1'b0, 1'b1, {2'd3, 32'(i)}, 3'b000);
      #1;
      checkOutput("sat_in_ready", 64'(linkReadyOut), 64'h1);
      if (i == 254) checkOutput("sat_pre", 64'(dropCount), 64'd254);
    end
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("sat_count", 64'(dropCount), 64'd255);
    checkOutput("sat_error", 64'(errorOut), 64'h1);

    // Ingress back-pressure: channel 2 full, channel 0 still accepted.
    doReset();
    chanEn = 3'b111;
    applyStimulus(3'b000, 1'b0, 1'b1, {2'd2, 32'h200}, 3'b000);
    #1;
    checkOutput("bp_first", 64'(linkReadyOut), 64'h1);
    applyStimulus(3'b000, 1'b0, 1'b1, {2'd2, 32'h201}, 3'b000);
    #1;
    checkOutput("bp_second", 64'(linkReadyOut), 64'h1);
    applyStimulus(3'b000, 1'b0, 1'b1, {2'd2, 32'h202}, 3'b000);
    #1;
    checkOutput("bp_third_blocked", 64'(linkReadyOut), 64'h0);
    checkOutput("bp_ch_v", 64'(chValidOut), 64'h4);
    applyStimulus(3'b000, 1'b0, 1'b1, {2'd0, 32'h300}, 3'b000);
    #1;
    checkOutput("bp_id0_ok", 64'(linkReadyOut), 64'h1);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("bp_ch_v_both", 64'(chValidOut), 64'h5);
    checkOutput("bp_head2", 64'(chDataOut[2]), 64'h200);
    checkOutput("bp_head0", 64'(chDataOut[0]), 64'h300);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b100);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("bp_head2_next", 64'(chDataOut[2]), 64'h201);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b100);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("bp_third_not_kept", 64'(chValidOut), 64'h1);

    // Mid-stall reset with every FIFO holding two words.
    doReset();
    chanEn   = 3'b111;
    chDataIn = {32'h602, 32'h601, 32'h600};
    for (int k = 0; k < 7; k++) begin
      applyStimulus(3'b000, 1'b0, 1'b1, {2'(k / 2), 32'h700 + 32'(k)}, 3'b000);
      #1;
      checkOutput("mr_in_ready", 64'(linkReadyOut), 64'h1);
    end
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("mr_in_full", 64'(chValidOut), 64'h7);
    checkOutput("mr_drop_pre", 64'(dropCount), 64'h1);
    applyStimulus(3'b111, 1'b0, 1'b0, '0, 3'b000);
    applyStimulus(3'b111, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("mr_grant0", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd0, 32'h600}));
    applyStimulus(3'b111, 1'b1, 1'b0, '0, 3'b000);
    #1;
    checkOutput("mr_xfer0", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd0, 32'h600}));
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("mr_lock1", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd1, 32'h601}));
    checkOutput("mr_all_full", 64'(chReadyOut), 64'h0);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    reset = 1'b1;
    #1;
    checkOutput("mr_during_reset", 64'({linkValidOut, chValidOut, chReadyOut}), 64'h0);
    applyStimulus(3'b111, 1'b0, 1'b0, '0, 3'b000);
    reset = 1'b0;
    #1;
    checkOutput("mr_link_v", 64'(linkValidOut), 64'h0);
    checkOutput("mr_ch_v", 64'(chValidOut), 64'h0);
    checkOutput("mr_drop", 64'(dropCount), 64'h0);
    checkOutput("mr_error", 64'(errorOut), 64'h0);
    checkOutput("mr_ch_ready", 64'(chReadyOut), 64'h7);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, 3'b000);
    #1;
    checkOutput("mr_first_grant", 64'({linkValidOut, linkDataOut}), 64'({1'b1, 2'd0, 32'h600}));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
